instr_mem_loader: RTL and testbench

- Write-side companion to the instruction memory: fills instruction words before the processor reads them by program counter.
- Takes a byte stream over a valid/ready handshake, packs four bytes MSB-first into 32-bit instructions, and issues single-cycle word writes.
- Write addresses auto-increment from 0.
- Drives the instruction memory write port while the core is held idle.

---
 rtl/instr_mem_loader_pkg.sv | 25 ++
 rtl/instr_mem_loader_if.sv | 22 ++
 rtl/instr_mem_loader_byte_packer.sv | 34 +++
 rtl/instr_mem_loader.sv | 161 ++++++++++++++++
 tb/tb_instr_mem_loader.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared constants and state encoding for the instruction memory loader.
// INSTR_LOADER_CHECKSUM_EN adds the CHECK state used by the trailing checksum byte.
package instr_mem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int INSTR_WIDTH    = 32;

`ifdef INSTR_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_FINISH  = 3'd3,
        ST_CHECK   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_FINISH  = 2'd3
    } state_t;
`endif

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface instr_mem_loader_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_mem_loader_byte_packer.sv
// Packs four stream bytes MSB-first into one instruction word.
module instr_byte_packer
    import instr_mem_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_in,
    output logic                   word_ready,
    output logic [INSTR_WIDTH-1:0] word_out
);

    logic [1:0]             cnt_q;
    logic [INSTR_WIDTH-1:0] shift_q;

    assign word_out   = {shift_q[INSTR_WIDTH-9:0], byte_in};
    assign word_ready = byte_valid && (cnt_q == 2'(BYTES_PER_WORD - 1));

    // byte counter and shift register; the counter wraps naturally after each word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (clear) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (byte_valid) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= word_out;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: byte stream in, one word write per four bytes.
// Optional trailing checksum byte: INSTR_LOADER_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | waiting for start, validates word_count
// COLLECT | accepting stream bytes into the packer
// WRITE   | one-cycle memory write of the assembled word
// FINISH  | one-cycle done pulse
// CHECK   | (checksum build) compares one byte with the running XOR
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = INSTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    instr_mem_loader_if.master    bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, mem_addr_q;
    logic [ADDR_WIDTH:0]     words_left_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic                    error_q, zero_done_q, rx_ready_c;
    logic                    in_idle, start_load, start_zero, start_bad;
    logic                    pack_take, word_ready, last_word;
    logic [INSTR_WIDTH-1:0]  packed_word;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]              sum_q;
    logic                    sum_take, sum_match;

    assign sum_take  = bus.rx_valid && (state_q == ST_CHECK);
    assign sum_match = (bus.rx_data == sum_q);
`endif

    assign in_idle    = (state_q == ST_IDLE);
    assign start_zero = in_idle && start && (word_count == '0);
    assign start_bad  = in_idle && start && (word_count > DEPTH_CNT);
    assign start_load = in_idle && start && (word_count != '0) && (word_count <= DEPTH_CNT);
    // rx_ready is constantly high in COLLECT, so valid alone qualifies a byte there
    assign pack_take  = bus.rx_valid && (state_q == ST_COLLECT);
    assign last_word  = (words_left_q == (ADDR_WIDTH+1)'(1));

    instr_byte_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (start_load),
        .byte_valid (pack_take),
        .byte_in    (bus.rx_data),
        .word_ready (word_ready),
        .word_out   (packed_word)
    );

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // next-state and stream handshake
    always_comb begin
        state_d    = state_q;
        rx_ready_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_load) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                rx_ready_c = 1'b1;
                if (word_ready) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (!last_word) begin
                    state_d = ST_COLLECT;
                end else begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_FINISH;
`endif
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                rx_ready_c = 1'b1;
                if (bus.rx_valid) state_d = sum_match ? ST_FINISH : ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // write address and remaining-word down-counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= '0;
            words_left_q <= '0;
        end else if (start_load) begin
            addr_q       <= '0;
            words_left_q <= word_count;
        end else if (state_q == ST_WRITE) begin
            addr_q       <= addr_q + ADDR_WIDTH'(1);
            words_left_q <= words_left_q - (ADDR_WIDTH+1)'(1);
        end
    end

    // write-port registers load as a word completes and hold between writes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (word_ready) begin
            mem_addr_q  <= addr_q;
            mem_wdata_q <= packed_word;
        end
    end

    // sticky error flag and the done pulse for an empty load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error_q     <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= start_zero;
            if (start_load)     error_q <= 1'b0;
            else if (start_bad) error_q <= 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            else if (sum_take && !sum_match) error_q <= 1'b1;
`endif
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    // running XOR of every data byte in the current load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       sum_q <= '0;
        else if (start_load) sum_q <= '0;
        else if (pack_take)  sum_q <= sum_q ^ bus.rx_data;
    end
`endif

    assign bus.rx_ready  = rx_ready_c;
    assign bus.mem_we    = (state_q == ST_WRITE);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = !in_idle;
    assign done          = (state_q == ST_FINISH) || zero_done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader with a byte-count level reference model.
module tb_instr_mem_loader;

    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;
    localparam logic [7:0] EX_BYTES [8] = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h22, 8'h18, 8'h20};

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [AW:0]   word_count;
    logic          busy, done, error;

    instr_mem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

    instr_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .word_count (word_count),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h @%0t", nm, act, req, $time);
        end
    endtask

    // reference model: expected outputs derived from accepted byte counts
    bit          m_active, m_we, m_done, m_err, m_chk, exp_ready;
    int          m_n, m_bytes, m_wr_addr, m_last_addr;
    logic [31:0] m_word, m_wr_data, m_last_data;
    logic [7:0]  m_xor;

    // observed DUT activity for literal end-of-test checks
    logic [31:0] mem_img [DEPTH];
    int          wr_count = 0, done_count = 0, last_wr_addr = -1;
    logic [7:0]  stim [4*DEPTH];
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]  csum_flip = 8'h00;
`endif

    always @(negedge clk) begin
        bit nx_we, nx_done, nx_active;
        if (!reset_n) begin
            m_active = 0; m_we = 0; m_done = 0; m_err = 0; m_chk = 0;
            m_n = 0; m_bytes = 0; m_wr_addr = 0; m_last_addr = 0;
            m_word = '0; m_wr_data = '0; m_last_data = '0; m_xor = '0;
            chk("rst_busy",     64'(busy),          64'(0));
            chk("rst_rx_ready", 64'(bus.rx_ready),  64'(0));
            chk("rst_mem_we",   64'(bus.mem_we),    64'(0));
            chk("rst_mem_addr", 64'(bus.mem_addr),  64'(0));
            chk("rst_wdata",    64'(bus.mem_wdata), 64'(0));
            chk("rst_done",     64'(done),          64'(0));
            chk("rst_error",    64'(error),         64'(0));
        end else begin
            if (m_we) begin
                m_last_addr = m_wr_addr;
                m_last_data = m_wr_data;
            end
            exp_ready = m_active && ((m_bytes < 4*m_n && !m_we) || m_chk);
            chk("busy",      64'(busy),          64'(m_active));
            chk("rx_ready",  64'(bus.rx_ready),  64'(exp_ready));
            chk("mem_we",    64'(bus.mem_we),    64'(m_we));
            chk("mem_addr",  64'(bus.mem_addr),  64'(m_last_addr));
            chk("mem_wdata", 64'(bus.mem_wdata), 64'(m_last_data));
            chk("done",      64'(done),          64'(m_done));
            chk("error",     64'(error),         64'(m_err));
            if (bus.mem_we) begin
                mem_img[bus.mem_addr] = bus.mem_wdata;
                wr_count++;
                last_wr_addr = int'(bus.mem_addr);
            end
            if (done) done_count++;

            nx_we = 0; nx_done = 0; nx_active = m_active;
            if (!m_active) begin
                if (start) begin
                    if (word_count == '0) nx_done = 1;
                    else if (int'(word_count) > DEPTH) m_err = 1;
                    else begin
                        nx_active = 1; m_n = int'(word_count); m_bytes = 0;
                        m_err = 0; m_xor = '0; m_chk = 0;
                    end
                end
            end else begin
                if (exp_ready && bus.rx_valid) begin
                    if (m_chk) begin
                        m_chk = 0;
                        if (bus.rx_data == m_xor) nx_done = 1;
                        else begin m_err = 1; nx_active = 0; end
                    end else begin
                        m_word  = {m_word[23:0], bus.rx_data};
                        m_xor   = m_xor ^ bus.rx_data;
                        m_bytes = m_bytes + 1;
                        if (m_bytes % 4 == 0) begin
                            nx_we     = 1;
                            m_wr_addr = m_bytes/4 - 1;
                            m_wr_data = m_word;
                        end
                    end
                end
                if (m_we && m_bytes == 4*m_n) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    m_chk = 1;
`else
                    nx_done = 1;
`endif
                end
                if (m_done) nx_active = 0;
            end
            m_we = nx_we; m_done = nx_done; m_active = nx_active;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        word_count = (AW+1)'(n);
        tick();
        start = 1'b0;
    endtask

    // gap: 0 back-to-back, 1 one idle cycle before each byte, 2 random idles
    task automatic push_byte(input logic [7:0] b, input int gap);
        int idle_n, guard;
        bit took;
        idle_n = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(2)) : 0;
        for (int i = 0; i < idle_n; i++) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            tick();
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        took = 0;
        guard = 0;
        while (!took && guard < 64) begin
            @(negedge clk);
            took = bus.rx_ready;
            tick();
            guard++;
        end
        chk("byte_accepted", 64'(took), 64'(1));
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int i = 0; i < 400 && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
        end
        chk("reached_idle", 64'(idle), 64'(1));
        tick();
        tick();
    endtask

    task automatic run_load(input int n, input int gap, input int mid_start);
`ifdef INSTR_LOADER_CHECKSUM_EN
        logic [7:0] xs;
        xs = '0;
`endif
        do_start(n);
        for (int k = 0; k < 4*n; k++) begin
            if (k == mid_start) begin
                start = 1'b1;
                word_count = (AW+1)'(3);
            end
            push_byte(stim[k], gap);
            start = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xs = xs ^ stim[k];
`endif
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        push_byte(xs ^ csum_flip, gap);
`endif
        bus.rx_valid = 1'b0;
        wait_idle();
    endtask

    task automatic clear_img();
        for (int i = 0; i < DEPTH; i++) mem_img[i] = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, d0, n, gap;
        reset_n = 1'b0; start = 1'b0; word_count = '0;
        bus.rx_valid = 1'b0; bus.rx_data = '0;
        clear_img();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // reset in the middle of COLLECT, then a clean one-word load
        do_start(1);
        push_byte(8'h11, 0);
        push_byte(8'h22, 0);
        bus.rx_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_busy",     64'(busy),         64'(0));
        chk("async_rst_rx_ready", 64'(bus.rx_ready), 64'(0));
        chk("async_rst_mem_we",   64'(bus.mem_we),   64'(0));
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        clear_img();
        w0 = wr_count;
        stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC; stim[3] = 8'hDD;
        run_load(1, 0, -1);
        chk("post_rst_word0",  64'(mem_img[0]),    64'(32'hAABBCCDD));
        chk("post_rst_writes", 64'(wr_count - w0), 64'(1));

        // reference two-word program, valid held high then toggling
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 8; i++) stim[i] = EX_BYTES[i];
            clear_img();
            w0 = wr_count; d0 = done_count;
            run_load(2, g, -1);
            chk("ex_word0",  64'(mem_img[0]),      64'(32'h8C010004));
            chk("ex_word1",  64'(mem_img[1]),      64'(32'h20221820));
            chk("ex_writes", 64'(wr_count - w0),   64'(2));
            chk("ex_dones",  64'(done_count - d0), 64'(1));
            chk("ex_busy",   64'(busy),            64'(0));
        end

        // empty and oversize loads
        w0 = wr_count; d0 = done_count;
        do_start(0);
        repeat (3) tick();
        chk("zero_dones",  64'(done_count - d0), 64'(1));
        chk("zero_writes", 64'(wr_count - w0),   64'(0));
        do_start(DEPTH + 1);
        repeat (2) tick();
        chk("over_error",  64'(error),         64'(1));
        chk("over_busy",   64'(busy),          64'(0));
        chk("over_writes", 64'(wr_count - w0), 64'(0));

        // full-depth load with an ignored start in the middle
        for (int i = 0; i < 4*DEPTH; i++) stim[i] = 8'($urandom);
        clear_img();
        w0 = wr_count;
        run_load(DEPTH, 0, 37);
        chk("full_writes",    64'(wr_count - w0), 64'(DEPTH));
        chk("full_last_addr", 64'(last_wr_addr),  64'(DEPTH - 1));
        chk("full_word0",     64'(mem_img[0]),    64'({stim[0], stim[1], stim[2], stim[3]}));
        chk("full_word_last", 64'(mem_img[DEPTH-1]),
            64'({stim[4*DEPTH-4], stim[4*DEPTH-3], stim[4*DEPTH-2], stim[4*DEPTH-1]}));
        chk("full_error",     64'(error),         64'(0));

`ifdef INSTR_LOADER_CHECKSUM_EN
        stim[0] = 8'h12; stim[1] = 8'h34; stim[2] = 8'h56; stim[3] = 8'h78;
        d0 = done_count;
        csum_flip = 8'h00;
        run_load(1, 0, -1);
        chk("csum_ok_done",  64'(done_count - d0), 64'(1));
        chk("csum_ok_error", 64'(error),           64'(0));
        d0 = done_count;
        csum_flip = 8'h01;
        run_load(1, 0, -1);
        chk("csum_bad_done",  64'(done_count - d0), 64'(0));
        chk("csum_bad_error", 64'(error),           64'(1));
        do_start(1);
        @(negedge clk);
        chk("csum_err_cleared", 64'(error), 64'(0));
        tick();
        for (int k = 0; k < 4; k++) push_byte(8'h00, 0);
        push_byte(8'h00, 0);
        bus.rx_valid = 1'b0;
        wait_idle();
`endif

        // randomized loads, including empty and oversize requests
        for (int t = 0; t < 20; t++) begin
            n   = int'($urandom_range(1, 6));
            gap = int'($urandom_range(0, 2));
            if ($urandom_range(7) == 0) n = 0;
            else if ($urandom_range(7) == 0) n = int'($urandom_range(DEPTH + 1, 2*DEPTH - 1));
            for (int i = 0; i < 4*DEPTH; i++) stim[i] = 8'($urandom);
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_flip = ($urandom_range(3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
`endif
            if (n == 0 || n > DEPTH) begin
                do_start(n);
                repeat (3) tick();
            end else begin
                run_load(n, gap, ($urandom_range(1) == 0) ? int'($urandom_range(0, 4*n - 1)) : -1);
            end
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
